// File: rtl/dut_top_pkg.sv
// dut_top_pkg: shared constants and helpers for the dut_top input conditioner.
//   DUT_TOP_STABLE_CNT_DEF : default STABLE_CNT parameter value
//   DUT_TOP_RST_VAL_DEF    : default reset level of the output and input flops
//   dut_top_cnt_w()        : width of the stability counter for a given STABLE_CNT
//   filt_act_e             : per-cycle filter decision
package dut_top_pkg;

  localparam int unsigned DUT_TOP_STABLE_CNT_DEF = 16;
  localparam logic        DUT_TOP_RST_VAL_DEF    = 1'b0;

  // Counter must hold values 0..STABLE_CNT; never narrower than one bit.
  function automatic int unsigned dut_top_cnt_w(input int unsigned stable_cnt);
    int unsigned w;
    w = $clog2(stable_cnt + 1);
    return (w < 1) ? 1 : w;
  endfunction

  typedef enum logic [1:0] {
    FILT_HOLD  = 2'd0,
    FILT_COUNT = 2'd1,
    FILT_FLIP  = 2'd2
  } filt_act_e;

endpackage : dut_top_pkg

// File: rtl/dut_top_if.sv
// dut_top_if: level-signal bundle between the conditioner and its neighbours.
//   I_data_in  : raw (possibly noisy) level toward the conditioner
//   O_data_out : filtered level from the conditioner
// master: the side that drives the raw level and consumes the filtered one.
// slave : the conditioner itself.
interface dut_top_if;

  logic I_data_in;
  logic O_data_out;

  modport master (
    output I_data_in,
    input  O_data_out
  );

  modport slave (
    input  I_data_in,
    output O_data_out
  );

endinterface : dut_top_if

// File: rtl/dut_top_sync.sv
// dut_top_sync: two-flop synchronizer for an asynchronous single-bit level.
//   I_clk      : destination clock
//   I_rst      : synchronous active-high reset, loads RST_VAL into both flops
//   I_data_in  : asynchronous level
//   O_data_out : level resynchronised to I_clk, straight from the second flop
module dut_top_sync
  import dut_top_pkg::*;
#(
  parameter logic RST_VAL = DUT_TOP_RST_VAL_DEF
) (
  input  logic I_clk,
  input  logic I_rst,
  input  logic I_data_in,
  output logic O_data_out
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= I_data_in;
      sync_q <= meta_q;
    end
  end

  assign O_data_out = sync_q;

endmodule : dut_top_sync

// File: rtl/dut_top.sv
// dut_top: single-bit debounce / glitch filter.
//   I_clk         : single clock, rising edge
//   I_rst         : synchronous active-high reset
//   bus (slave)   : bus.I_data_in raw level in, bus.O_data_out filtered level out
// Parameters:
//   STABLE_CNT    : stability threshold (1..65535)
//   RST_VAL       : reset level of the output and all input flops
// Build option:
//   DUT_TOP_SYNC_EN defined -> a 2-flop synchronizer precedes the sample flop,
//   for an asynchronous I_data_in (adds two cycles of latency).
// The sampled level must differ from the output on STABLE_CNT+1 consecutive
// filter evaluations before the output takes it; any agreeing sample restarts
// the count. Output latency is STABLE_CNT+1 edges after the sample flop first
// captures the new level, so pulses of STABLE_CNT cycles or fewer are dropped.
module dut_top
  import dut_top_pkg::*;
#(
  parameter int unsigned STABLE_CNT = DUT_TOP_STABLE_CNT_DEF,
  parameter logic        RST_VAL    = DUT_TOP_RST_VAL_DEF
) (
  input  logic      I_clk,
  input  logic      I_rst,
  dut_top_if.slave  bus
);

  localparam int unsigned      CNT_W    = dut_top_cnt_w(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT);

  logic             sample_c;
  logic             din_q;
  logic             out_q;
  logic             out_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  filt_act_e        act;

  // Optional resynchronisation ahead of the sample flop.
`ifdef DUT_TOP_SYNC_EN
  dut_top_sync #(
    .RST_VAL    (RST_VAL)
  ) u_sync (
    .I_clk      (I_clk),
    .I_rst      (I_rst),
    .I_data_in  (bus.I_data_in),
    .O_data_out (sample_c)
  );
`else
  assign sample_c = bus.I_data_in;
`endif

  // State registers: sample flop, stability counter, filtered output.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      din_q <= RST_VAL;
      cnt_q <= '0;
      out_q <= RST_VAL;
    end else begin
      din_q <= sample_c;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  // Filter decision: hold when sample agrees, count while it differs,
  // flip once the count has already reached STABLE_CNT.
  always_comb begin
    act   = FILT_HOLD;
    cnt_d = '0;
    out_d = out_q;
    if (din_q != out_q) begin
      if (cnt_q == CNT_LAST) begin
        act = FILT_FLIP;
      end else begin
        act = FILT_COUNT;
      end
    end
    unique case (act)
      FILT_COUNT: cnt_d = cnt_q + CNT_W'(1);
      FILT_FLIP: begin
        out_d = din_q;
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
        out_d = out_q;
      end
    endcase
  end

  assign bus.O_data_out = out_q;

endmodule : dut_top

// File: tb/tb_dut_top.sv
// tb_dut_top: self-checking bench for dut_top (STABLE_CNT=16, 20-unit clock).
module tb_dut_top;

  localparam int unsigned STABLE_CNT = 16;
`ifdef DUT_TOP_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 0;
`endif
  localparam int WIN       = STABLE_CNT + 1;
  localparam int LAT       = WIN + SYNC_D;
  localparam int MAX_EDGES = 16384;
  localparam int NVEC      = 6;

  typedef struct {
    bit rst;
    bit din;
    int ncyc;
    bit exp_end;
    int exp_edges;
    int exp_lat;
  } vec_t;

  logic clk;
  logic rst;

  dut_top_if bus();

  dut_top #(
    .STABLE_CNT (STABLE_CNT),
    .RST_VAL    (1'b0)
  ) dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int   vec_cnt;
  int   err_cnt;
  int   edge_n;
  int   last_evt;
  bit   din_h [MAX_EDGES];
  bit   m_out;
  bit   m_s1;
  bit   m_s2;
  bit   exp_q [$];
  vec_t vecs [NVEC];

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output flips at edge e iff the sample flop held the opposite level after
  // each of the WIN previous edges, all after the last reset or flip.
  function automatic bit model_flip(input int e);
    if (e - WIN < last_evt) return 1'b0;
    for (int j = 1; j <= WIN; j++) begin
      if (din_h[e - j] == m_out) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check_out();
    bit exp;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      exp = exp_q.pop_front();
      vec_cnt++;
      if (bus.O_data_out !== exp) begin
        err_cnt++;
        $display("FAIL out_edge%0d: got %b expected %b (t=%0t)", edge_n, bus.O_data_out, exp, $time);
      end
    end
  endtask

  // One clock: drive, update the reference, push expectation, sample at +1.
  task automatic step(input bit r, input bit d);
    bit m_in;
    rst           = r;
    bus.I_data_in = d;
    @(posedge clk);
    edge_n++;
    if (edge_n >= MAX_EDGES - 1) begin
      $display("FAIL edge_budget: got %0d expected below %0d", edge_n, MAX_EDGES - 1);
      $fatal(1, "edge budget exhausted");
    end
    if (r) begin
      m_out          = 1'b0;
      m_s1           = 1'b0;
      m_s2           = 1'b0;
      last_evt       = edge_n;
      din_h[edge_n]  = 1'b0;
    end else begin
      if (model_flip(edge_n)) begin
        m_out    = ~m_out;
        last_evt = edge_n;
      end
      m_in          = (SYNC_D != 0) ? m_s2 : d;
      m_s2          = m_s1;
      m_s1          = d;
      din_h[edge_n] = m_in;
    end
    exp_q.push_back(m_out);
    #1;
    check_out();
  endtask

  // Drive a 1-pulse of width w on a steady-0 line; return cycles the output was high.
  task automatic pulse(input int w, output int hi);
    hi = 0;
    for (int c = 0; c < w + 100; c++) begin
      step(1'b0, (c < w) ? 1'b1 : 1'b0);
      if (bus.O_data_out === 1'b1) hi++;
    end
  endtask

  initial begin
    int hi;
    int lat;
    vec_cnt  = 0;
    err_cnt  = 0;
    edge_n   = 0;
    last_evt = 0;
    m_out    = 1'b0;
    m_s1     = 1'b0;
    m_s2     = 1'b0;
    rst      = 1'b1;
    bus.I_data_in = 1'b0;

    vecs[0] = '{rst: 1'b0, din: 1'b1, ncyc: 2000, exp_end: 1'b1, exp_edges: 1, exp_lat: LAT};
    vecs[1] = '{rst: 1'b0, din: 1'b0, ncyc: 2000, exp_end: 1'b0, exp_edges: 1, exp_lat: LAT};
    vecs[2] = '{rst: 1'b0, din: 1'b1, ncyc: 2000, exp_end: 1'b1, exp_edges: 1, exp_lat: LAT};
    vecs[3] = '{rst: 1'b0, din: 1'b1, ncyc: 40,   exp_end: 1'b1, exp_edges: 0, exp_lat: -1};
    vecs[4] = '{rst: 1'b0, din: 1'b0, ncyc: 2000, exp_end: 1'b0, exp_edges: 1, exp_lat: LAT};
    vecs[5] = '{rst: 1'b0, din: 1'b0, ncyc: 40,   exp_end: 1'b0, exp_edges: 0, exp_lat: -1};

    // Long reset with input low: output and counter pinned at zero.
    for (int c = 0; c < 200; c++) begin
      step(1'b1, 1'b0);
      chk("rst_cnt", int'(dut.cnt_q), 0);
    end
    chk("rst_out", int'(bus.O_data_out), 0);

    // Level steps: one output edge per input edge, at fixed latency.
    for (int i = 0; i < NVEC; i++) begin
      int edges;
      int seg_lat;
      logic prev;
      edges   = 0;
      seg_lat = -1;
      prev    = bus.O_data_out;
      for (int c = 0; c < vecs[i].ncyc; c++) begin
        step(vecs[i].rst, vecs[i].din);
        if (bus.O_data_out !== prev) begin
          edges++;
          if (seg_lat < 0) seg_lat = c;
          prev = bus.O_data_out;
        end
      end
      chk($sformatf("vec%0d_end", i), int'(bus.O_data_out), int'(vecs[i].exp_end));
      chk($sformatf("vec%0d_edges", i), edges, vecs[i].exp_edges);
      chk($sformatf("vec%0d_latency", i), seg_lat, vecs[i].exp_lat);
    end

    // Pulse rejection / propagation on a steady-0 line.
    pulse(1, hi);
    chk("pulse_1", hi, 0);
    pulse(int'(STABLE_CNT), hi);
    chk("pulse_stable_cnt", hi, 0);
    pulse(int'(STABLE_CNT) + 1, hi);
    chk("pulse_stable_cnt_p1", hi, int'(STABLE_CNT) + 1);
    pulse(30, hi);
    chk("pulse_30", hi, 30);

    // Broken runs: a single agreeing sample restarts the count.
    hi = 0;
    for (int c = 0; c < 2 * int'(STABLE_CNT) + 60; c++) begin
      step(1'b0, (c == int'(STABLE_CNT)) || (c > 2 * int'(STABLE_CNT)) ? 1'b0 : 1'b1);
      if (bus.O_data_out === 1'b1) hi++;
    end
    chk("broken_run", hi, 0);

    // Toggling every cycle never reaches the output.
    hi = 0;
    for (int c = 0; c < 200; c++) begin
      step(1'b0, c[0]);
      if (bus.O_data_out === 1'b1) hi++;
    end
    chk("toggle", hi, 0);
    for (int c = 0; c < 40; c++) step(1'b0, 1'b0);

    // Reset in the middle of a count discards the partial count.
    for (int c = 0; c <= 10; c++) step(1'b0, 1'b1);
    chk("cnt_before_rst", int'(dut.cnt_q), 10 - SYNC_D);
    step(1'b1, 1'b1);
    chk("mid_rst_out", int'(bus.O_data_out), 0);
    chk("mid_rst_cnt", int'(dut.cnt_q), 0);
    lat = -1;
    for (int c = 0; c < 60; c++) begin
      step(1'b0, 1'b1);
      if (lat < 0 && bus.O_data_out === 1'b1) lat = c;
    end
    chk("post_rst_latency", lat, LAT);
    chk("post_rst_out", int'(bus.O_data_out), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_dut_top
